// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// Word-organised synchronous RAM behind a req/ready handshake with programmable wait states.
// Optional feature macro: DMEM_BYTE_LANES_EN
//   defined   -> RV32 byte/half/word accesses with lane shift and sign/zero extension
//   undefined -> word-only accesses; size is ignored and treated as LW
module dmem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_err
);

  localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_idle;
  logic        w_enter_resp;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_offset;
  logic        w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic        w_bad_size;
  logic        w_misalign;
  logic        w_err;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic [31:0] w_word;
  logic [31:0] w_wmerged;
  logic [31:0] w_load;

`ifdef DMEM_BYTE_LANES_EN
  logic [2:0]  r_size;
  logic [2:0]  w_size;
  logic [31:0] w_shifted;
`else
  logic        w_unused_size;
  assign w_unused_size = ^i_size;
`endif

  // With zero wait states the array is touched on the accept edge itself, so the live
  // inputs are used there; afterwards only the captured copy is used.
  assign w_idle  = (r_state == StIdle);
  assign w_we    = w_idle ? i_we    : r_we;
  assign w_addr  = w_idle ? i_addr  : r_addr;
  assign w_wdata = w_idle ? i_wdata : r_wdata;
`ifdef DMEM_BYTE_LANES_EN
  assign w_size  = w_idle ? i_size  : r_size;
`endif

  assign w_offset   = w_addr - BASE_ADDR;
  assign w_in_range = (w_addr >= BASE_ADDR) && ({1'b0, w_offset} < SPAN);
  assign w_idx      = w_offset[IDX_W+1:2];
  assign w_word     = r_mem[w_idx];
  assign w_err      = !w_in_range || w_bad_size || w_misalign;

  // State register and wait counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: accept in idle, count down wait states, single response cycle
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          if (WAIT_CYCLES > 0) begin
            w_state_next = StWait;
            w_cnt_next   = WAIT_INIT;
          end else begin
            w_state_next = StResp;
          end
        end
      end
      StWait: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = StResp;
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    w_enter_resp = (w_state_next == StResp) && (r_state != StResp) && !i_rst;
  end

  // Capture the request fields on accept so later input changes have no effect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
`ifdef DMEM_BYTE_LANES_EN
      r_size  <= '0;
`endif
    end else if (w_idle && i_req) begin
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
`ifdef DMEM_BYTE_LANES_EN
      r_size  <= i_size;
`endif
    end
  end

  // Size legality, alignment, store lane enables and load alignment/extension
  always_comb begin
    w_bad_size = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b0000;
    w_wlane    = 32'd0;
    w_load     = 32'd0;
`ifdef DMEM_BYTE_LANES_EN
    w_shifted  = w_word >> {w_addr[1:0], 3'b000};
    w_bad_size = (w_size[1:0] == 2'b11) || (w_size[2] && w_size[1]) || (w_we && w_size[2]);
    w_misalign = ((w_size[1:0] == 2'b01) && w_addr[0]) ||
                 ((w_size[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
    case (w_size[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wlane = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_addr[1], 1'b0};
        w_wlane = {2{w_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wlane = w_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wlane = 32'd0;
      end
    endcase
    case (w_size)
      3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_load = {24'd0, w_shifted[7:0]};
      3'b101:  w_load = {16'd0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
`else
    w_misalign = (w_addr[1:0] != 2'b00);
    w_be       = 4'b1111;
    w_wlane    = w_wdata;
    w_load     = w_word;
`endif
  end

  // Merge the selected store lanes into the current word
  always_comb begin
    w_wmerged = w_word;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_wmerged[8*b +: 8] = w_wlane[8*b +: 8];
    end
  end

  // Array write on the edge entering the response state; contents are never reset
  always_ff @(posedge i_clk) begin
    if (w_enter_resp && w_we && !w_err) begin
      r_mem[w_idx] <= w_wmerged;
    end
  end

  // Response data and error flag, held until the next response
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else if (w_enter_resp) begin
      r_err   <= w_err;
      r_rdata <= (w_we || w_err) ? 32'd0 : w_load;
    end
  end

  assign o_ready = (r_state == StResp);
  assign o_err   = o_ready && r_err;
  assign o_rdata = r_rdata;

endmodule
